// File: rtl/noc_input_port.sv
// noc_input_port: requesting side of a mesh router input.
// Buffers single-flit packets in a FIFO, computes the XY route of the head
// flit, raises a one-hot port request and waits for grant/fail. A grant
// forwards the head to the crossbar; a fail backs off for BACKOFF cycles
// and then re-requests.
// Optional build macro NOC_INPUT_RETRY_STATS_EN adds the retry_cnt and
// starved outputs.
module noc_input_port #(
    parameter int DATA_W  = 16,
    parameter int COORD_W = 2,
    parameter int CUR_X   = 0,
    parameter int CUR_Y   = 0,
    parameter int DEPTH   = 4,
    parameter int BACKOFF = 3
) (
    input  logic              clk,
    input  logic              rst_n,      // synchronous, active-high
    input  logic              in_valid,
    input  logic [DATA_W-1:0] in_data,
    output logic              in_ready,
    output logic [2:0]        req,
    input  logic              grant,
    input  logic              fail,
    output logic              out_valid,
    output logic [DATA_W-1:0] out_data,
    output logic [1:0]        out_port
`ifdef NOC_INPUT_RETRY_STATS_EN
    ,
    output logic [7:0]        retry_cnt,
    output logic              starved
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam int BW = ($clog2(BACKOFF + 1) < 1) ? 1 : $clog2(BACKOFF + 1);
    localparam int HW = 2 * COORD_W;

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_BACKOFF
    } state_e;

    // One-hot route of a flit header: X first, then Y, else local.
    function automatic logic [2:0] route_of(input logic [HW-1:0] hdr);
        logic [COORD_W-1:0] dest_x;
        logic [COORD_W-1:0] dest_y;
        dest_x = hdr[COORD_W-1:0];
        dest_y = hdr[HW-1:COORD_W];
        if (dest_x != COORD_W'(CUR_X))      return 3'b001;
        else if (dest_y != COORD_W'(CUR_Y)) return 3'b010;
        else                                return 3'b100;
    endfunction

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q, rd_ptr_nx;
    logic [CW-1:0]     count_q, count_d;
    logic              push, pop, empty;
    logic [DATA_W-1:0] head;
    logic [HW-1:0]     next_hdr;

    state_e            state_q;
    logic [2:0]        req_q;
    logic [BW-1:0]     bo_q;
    logic              out_valid_q;
    logic [DATA_W-1:0] out_data_q;
    logic [1:0]        out_port_q;

    assign in_ready  = (count_q != CW'(DEPTH));
    assign empty     = (count_q == '0);
    assign push      = in_valid && in_ready;
    assign pop       = (state_q == S_REQ) && grant;
    assign head      = mem_q[rd_ptr_q];
    assign rd_ptr_nx = rd_ptr_q + AW'(1);

    // Header of the flit that becomes head after a pop. With a single flit
    // buffered it can only be the one being written in the same cycle.
    assign next_hdr = (count_q > CW'(1)) ? mem_q[rd_ptr_nx][HW-1:0]
                                         : in_data[HW-1:0];

    // Occupancy after this cycle's push/pop.
    always_comb begin
        // NOTE: default assignment first so no path leaves count_d unassigned (no latch).
        count_d = count_q;
        case ({push, pop})
            2'b10:   count_d = count_q + CW'(1);
            2'b01:   count_d = count_q - CW'(1);
            default: count_d = count_q;
        endcase
    end

    // FIFO storage; written only on an accepted upstream flit.
    always_ff @(posedge clk) begin
        // NOTE: storage is not reset; an empty count makes stale entries unreachable.
        if (push) mem_q[wr_ptr_q] <= in_data;
    end

    // FIFO pointers and occupancy counter; pointers wrap modulo DEPTH.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            // NOTE: non-blocking so every register samples pre-edge values.
            if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (pop)  rd_ptr_q <= rd_ptr_nx;
            count_q <= count_d;
        end
    end

    // Request FSM with registered req and crossbar outputs.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            state_q     <= S_IDLE;
            req_q       <= '0;
            bo_q        <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_port_q  <= '0;
        end else begin
            out_valid_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (!empty) begin
                        state_q <= S_REQ;
                        req_q   <= route_of(head[HW-1:0]);
                    end
                end
                S_REQ: begin
                    // grant wins over a simultaneous fail
                    if (grant) begin
                        out_valid_q <= 1'b1;
                        out_data_q  <= head;
                        // one-hot X/Y bits map directly onto the 01/10/00 port code
                        out_port_q  <= req_q[1:0];
                        if (count_d != '0) begin
                            req_q <= route_of(next_hdr);
                        end else begin
                            state_q <= S_IDLE;
                            req_q   <= '0;
                        end
                    end else if (fail) begin
                        state_q <= S_BACKOFF;
                        req_q   <= '0;
                        bo_q    <= BW'(BACKOFF);
                    end
                end
                S_BACKOFF: begin
                    if (bo_q == BW'(1)) begin
                        state_q <= S_REQ;
                        req_q   <= route_of(head[HW-1:0]);
                    end else begin
                        bo_q <= bo_q - BW'(1);
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    req_q   <= '0;
                end
            endcase
        end
    end

    assign req       = req_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;
    assign out_port  = out_port_q;

`ifdef NOC_INPUT_RETRY_STATS_EN
    logic [7:0] retry_q;
    logic [3:0] fail_run_q;

    // Saturating total-fail count and per-head consecutive-fail run.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            retry_q    <= '0;
            fail_run_q <= '0;
        end else if (state_q == S_REQ) begin
            if (grant) begin
                fail_run_q <= '0;
            end else if (fail) begin
                if (retry_q != 8'hFF) retry_q <= retry_q + 8'd1;
                if (!fail_run_q[3])   fail_run_q <= fail_run_q + 4'd1;
            end
        end
    end

    assign retry_cnt = retry_q;
    assign starved   = fail_run_q[3];
`endif

endmodule

// File: tb/tb_noc_input_port.sv
// Self-checking bench for noc_input_port (CUR=(0,0), DEPTH=4, BACKOFF=3).
// Expected flits are queued when accepted and compared when out_valid fires.
module tb_noc_input_port;

    localparam int DATA_W = 16;
    localparam int DEPTH  = 4;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [2:0]        req;
        logic [1:0]        port;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              in_valid;
    logic [DATA_W-1:0] in_data;
    logic              in_ready;
    logic [2:0]        req;
    logic              grant;
    logic              fail;
    logic              out_valid;
    logic [DATA_W-1:0] out_data;
    logic [1:0]        out_port;
`ifdef NOC_INPUT_RETRY_STATS_EN
    logic [7:0]        retry_cnt;
    logic              starved;
`endif

    int   total = 0;
    int   bad   = 0;
    int   model_cnt = 0;
    exp_t sb_q[$];

    noc_input_port dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .req       (req),
        .grant     (grant),
        .fail      (fail),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_port  (out_port)
`ifdef NOC_INPUT_RETRY_STATS_EN
        ,
        .retry_cnt (retry_cnt),
        .starved   (starved)
`endif
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference route for CUR=(0,0).
    function automatic exp_t make_exp(input logic [DATA_W-1:0] f);
        exp_t e;
        e.data = f;
        if (f[1:0] != 2'd0) begin
            e.req = 3'b001; e.port = 2'b01;
        end else if (f[3:2] != 2'd0) begin
            e.req = 3'b010; e.port = 2'b10;
        end else begin
            e.req = 3'b100; e.port = 2'b00;
        end
        return e;
    endfunction

    function automatic logic [DATA_W-1:0] flit(input logic [11:0] tag,
                                               input logic [1:0] dx, input logic [1:0] dy);
        return {tag, dy, dx};
    endfunction

    // Step to just after the next falling edge (monitor has already run).
    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    // Scoreboard compare on every forwarded flit.
    always @(negedge clk) begin
        if (out_valid === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_out", 32'(out_data), 32'hFFFF_FFFF);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("out_data", 32'(out_data), 32'(e.data));
                check("out_port", 32'(out_port), 32'(e.port));
                model_cnt--;
            end
        end
    end

    task automatic push_flit(input logic [DATA_W-1:0] d);
        check("in_ready", 32'(in_ready), 32'(model_cnt < DEPTH));
        in_valid = 1'b1;
        in_data  = d;
        if (model_cnt < DEPTH) begin
            sb_q.push_back(make_exp(d));
            model_cnt++;
        end
        tick();
        in_valid = 1'b0;
    endtask

    task automatic wait_req();
        int n = 0;
        while (req == 3'b000 && n < 50) begin
            tick();
            n++;
        end
        check("req_seen", 32'(req != 3'b000), 32'd1);
    endtask

    task automatic do_grant();
        wait_req();
        if (sb_q.size() != 0) check("req_onehot", 32'(req), 32'(sb_q[0].req));
        grant = 1'b1;
        tick();
        grant = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        in_data  = '0;
        grant    = 1'b0;
        fail     = 1'b0;

        // Reset state
        tick();
        tick();
        check("rst_req",       32'(req),       32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data",  32'(out_data),  32'd0);
        check("rst_out_port",  32'(out_port),  32'd0);
        check("rst_in_ready",  32'(in_ready),  32'd1);
        rst_n = 1'b0;
        tick();

        // Single flit to (2,1): X route
        push_flit(flit(12'hA51, 2'd2, 2'd1));
        do_grant();
        tick();
        check("t1_pulse_off", 32'(out_valid), 32'd0);
        check("t1_req_idle",  32'(req),       32'd0);
        check("t1_ready",     32'(in_ready),  32'd1);
        check("t1_hold_port", 32'(out_port),  32'b01);

        // (0,3) then (0,0), second pushed in the same cycle as the grant
        push_flit(flit(12'hB03, 2'd0, 2'd3));
        wait_req();
        check("t2_req_y", 32'(req), 32'b010);
        check("t2_ready", 32'(in_ready), 32'd1);
        grant    = 1'b1;
        in_valid = 1'b1;
        in_data  = flit(12'hC00, 2'd0, 2'd0);
        sb_q.push_back(make_exp(in_data));
        model_cnt++;
        tick();
        grant    = 1'b0;
        in_valid = 1'b0;
        check("t2_req_local", 32'(req), 32'b100);
        do_grant();
        tick();

        // Fail then BACKOFF: req low for exactly 3 cycles
        push_flit(flit(12'hD10, 2'd1, 2'd0));
        wait_req();
        fail = 1'b1;
        tick();
        fail = 1'b0;
        n = 0;
        while (req == 3'b000 && n < 20) begin
            n++;
            tick();
        end
        check("t3_backoff_len", 32'(n), 32'd3);
        check("t3_rereq", 32'(req), 32'b001);
        do_grant();
        tick();

        // Fill FIFO without grants, 5th write refused
        push_flit(flit(12'h111, 2'd1, 2'd1));
        push_flit(flit(12'h222, 2'd0, 2'd2));
        push_flit(flit(12'h333, 2'd0, 2'd0));
        push_flit(flit(12'h444, 2'd3, 2'd0));
        check("t4_full", 32'(in_ready), 32'd0);
        push_flit(flit(12'h555, 2'd2, 2'd2));
        check("t4_still_full", 32'(in_ready), 32'd0);
        do_grant();
        check("t4_ready_after_pop", 32'(in_ready), 32'd1);
        do_grant();
        do_grant();
        do_grant();
        tick();
        check("t4_drained_req", 32'(req), 32'd0);
        check("t4_sb_empty", 32'(sb_q.size()), 32'd0);

        // Reset while requesting with 2 flits buffered
        push_flit(flit(12'h666, 2'd1, 2'd0));
        push_flit(flit(12'h777, 2'd0, 2'd1));
        wait_req();
        rst_n = 1'b1;
        sb_q.delete();
        model_cnt = 0;
        tick();
        rst_n = 1'b0;
        check("t5_req",       32'(req),       32'd0);
        check("t5_out_valid", 32'(out_valid), 32'd0);
        check("t5_ready",     32'(in_ready),  32'd1);
        check("t5_out_data",  32'(out_data),  32'd0);
        grant = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t5_no_out", 32'(out_valid), 32'd0);
        end
        grant = 1'b0;
        check("t5_req_after", 32'(req), 32'd0);

`ifdef NOC_INPUT_RETRY_STATS_EN
        // Eight consecutive fails on one head
        push_flit(flit(12'h888, 2'd0, 2'd2));
        for (int i = 0; i < 8; i++) begin
            wait_req();
            fail = 1'b1;
            tick();
            fail = 1'b0;
            if (i == 6) check("t6_not_starved_7", 32'(starved), 32'd0);
        end
        check("t6_retry_8", 32'(retry_cnt), 32'd8);
        check("t6_starved", 32'(starved),   32'd1);
        do_grant();
        check("t6_starved_clr", 32'(starved),   32'd0);
        check("t6_retry_hold",  32'(retry_cnt), 32'd8);
`endif

        tick();
        tick();
        check("final_sb_empty", 32'(sb_q.size()), 32'd0);
        check("final_idle_out", 32'(out_valid), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
